rotary_valve_sequencer: RTL

- Electronic control stage directly upstream of the rotary-cell chip. Drives its 13 pneumatic valve control lines (cb1_1..cb6_2).
- Runs one load–mix–deliver job per accepted command:
  - route inlet pb1_k through input mux m1 into the rotary mixer;
  - peristaltically mix for N rotations;
  - route the product through output mux m2 into trap b1_j.
- Sits between the host command interface and the chip's valve manifold.

---
 rtl/rotary_pkg.sv | 68 ++++++
 rtl/peristaltic_phase_gen.sv | 66 ++++++
 rtl/rotary_valve_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary-cell valve sequencer: state codes, valve
// bit map, pump phase table and mux select encoding.
package rotary_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_ROUTE_IN  = 4'd1;
  localparam state_t ST_FILL      = 4'd2;
  localparam state_t ST_SEAL      = 4'd3;
  localparam state_t ST_MIX       = 4'd4;
  localparam state_t ST_ROUTE_OUT = 4'd5;
  localparam state_t ST_DRAIN     = 4'd6;
  localparam state_t ST_DONE      = 4'd7;
  localparam state_t ST_ABORT     = 4'd8;

  localparam int NUM_VALVES = 13;

  localparam int V_CB1_1 = 0;
  localparam int V_CB1_2 = 1;
  localparam int V_CB2_1 = 2;
  localparam int V_CB2_2 = 3;
  localparam int V_CB3_1 = 4;
  localparam int V_CB3_2 = 5;
  localparam int V_CB3_3 = 6;
  localparam int V_CB4_1 = 7;
  localparam int V_CB4_2 = 8;
  localparam int V_CB5_1 = 9;
  localparam int V_CB5_2 = 10;
  localparam int V_CB6_1 = 11;
  localparam int V_CB6_2 = 12;

  localparam logic [NUM_VALVES-1:0] VALVES_CLOSED = 13'h1FFF;

  // Pump patterns are ordered {cb3_1, cb3_2, cb3_3}.
  localparam logic [2:0] PUMP_IDLE      = 3'b111;
  localparam logic [2:0] PUMP_LAST_PHASE = 3'd5;

  typedef struct packed {
    logic [1:0] inlet;
    logic [1:0] trap;
    logic [7:0] mix_rot;
  } job_t;

  function automatic logic [2:0] pump_phase(input logic [2:0] idx);
    logic [2:0] pat;
    case (idx)
      3'd0:    pat = 3'b101;
      3'd1:    pat = 3'b100;
      3'd2:    pat = 3'b110;
      3'd3:    pat = 3'b010;
      3'd4:    pat = 3'b011;
      3'd5:    pat = 3'b001;
      default: pat = PUMP_IDLE;
    endcase
    return pat;
  endfunction

  // Returns {cbX_2, cbX_1, cbY_2, cbY_1} for a two-stage binary mux.
  function automatic logic [3:0] mux_encode(input logic [1:0] sel);
    return {~sel[1], sel[1], ~sel[0], sel[0]};
  endfunction

  function automatic logic is_pumping(input state_t s);
    return (s == ST_FILL) || (s == ST_MIX) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/peristaltic_phase_gen.sv
// Three-valve peristaltic pump sequencer; holds each phase STEP_DIV cycles and
// flags the last cycle of every full rotation.
module peristaltic_phase_gen
  import rotary_pkg::*;
#(
  parameter int STEP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  output logic [2:0] pattern,
  output logic       rotation_tick
);

  localparam logic [15:0] DIV_LOAD = 16'(STEP_DIV - 1);

  logic [2:0]  phase_q, phase_d;
  logic [15:0] div_q, div_d;
  logic        active_q, active_d;
  logic [2:0]  pattern_q, pattern_d;

  // enable/clear describe the coming cycle, so pattern_q lines up with the
  // state register in the parent.
  always_comb begin
    phase_d  = phase_q;
    div_d    = div_q;
    active_d = active_q;
    if (clear) begin
      phase_d  = 3'd0;
      div_d    = DIV_LOAD;
      active_d = 1'b1;
    end else if (enable) begin
      active_d = 1'b1;
      if (div_q == 16'd0) begin
        div_d   = DIV_LOAD;
        phase_d = (phase_q == PUMP_LAST_PHASE) ? 3'd0 : phase_q + 3'd1;
      end else begin
        div_d = div_q - 16'd1;
      end
    end else begin
      phase_d  = 3'd0;
      div_d    = DIV_LOAD;
      active_d = 1'b0;
    end
    pattern_d = active_d ? pump_phase(phase_d) : PUMP_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= 3'd0;
      div_q     <= 16'd0;
      active_q  <= 1'b0;
      pattern_q <= PUMP_IDLE;
    end else begin
      phase_q   <= phase_d;
      div_q     <= div_d;
      active_q  <= active_d;
      pattern_q <= pattern_d;
    end
  end

  assign pattern       = pattern_q;
  assign rotation_tick = active_q && (phase_q == PUMP_LAST_PHASE) && (div_q == 16'd0);

endmodule

// File: rtl/rotary_valve_sequencer.sv
// Load-mix-deliver job sequencer driving the rotary-cell valve manifold.
//   state     | meaning
//   IDLE      | all valves closed, ready for a command
//   ROUTE_IN  | m1 routes inlet to mixer, settle timer running
//   FILL      | as ROUTE_IN with pump running FILL_ROT rotations
//   SEAL      | mixer isolated, settle timer running
//   MIX       | mixer isolated, pump running mix_rot rotations
//   ROUTE_OUT | m2 routes mixer to trap, settle timer running
//   DRAIN     | as ROUTE_OUT with pump running DRAIN_ROT rotations
//   DONE      | all closed, done pulse
//   ABORT     | all closed, aborted pulse
module rotary_valve_sequencer
  import rotary_pkg::*;
#(
  parameter int STEP_DIV  = 4,
  parameter int SETTLE    = 8,
  parameter int FILL_ROT  = 2,
  parameter int DRAIN_ROT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_inlet,
  input  logic [1:0]  cmd_trap,
  input  logic [7:0]  cmd_mix_rot,
  input  logic        abort,
  output logic [12:0] valve,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE - 1);
  localparam logic [7:0]  FILL_LOAD   = 8'(FILL_ROT);
  localparam logic [7:0]  DRAIN_LOAD  = 8'(DRAIN_ROT);

  state_t       state_q, state_d;
  logic [15:0]  timer_q, timer_d;
  logic [7:0]   rot_q, rot_d;
  job_t         job_q, job_d;
  logic [12:0]  valve_q, valve_d;

  logic         pump_enable;
  logic         pump_clear;
  logic [2:0]   pump_pat;
  logic         rotation_tick;

  function automatic logic [12:0] static_valves(input state_t s, input job_t j);
    logic [12:0] v;
    v = VALVES_CLOSED;
    case (s)
      ST_ROUTE_IN, ST_FILL: begin
        v[V_CB2_2:V_CB1_1] = mux_encode(j.inlet);
        v[V_CB4_1]         = 1'b0;
      end
      ST_ROUTE_OUT, ST_DRAIN: begin
        v[V_CB6_2:V_CB5_1] = mux_encode(j.trap);
        v[V_CB4_2]         = 1'b0;
      end
      default: v = VALVES_CLOSED;
    endcase
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rot_d   = rot_q;
    job_d   = job_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          job_d.inlet   = cmd_inlet;
          job_d.trap    = cmd_trap;
          job_d.mix_rot = cmd_mix_rot;
          timer_d       = SETTLE_LOAD;
          state_d       = ST_ROUTE_IN;
        end
      end
      ST_ROUTE_IN: begin
        if (timer_q == 16'd0) begin
          rot_d   = FILL_LOAD;
          state_d = ST_FILL;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_FILL: begin
        if (rotation_tick) begin
          if (rot_q == 8'd1) begin
            timer_d = SETTLE_LOAD;
            state_d = ST_SEAL;
          end else begin
            rot_d = rot_q - 8'd1;
          end
        end
      end
      ST_SEAL: begin
        if (timer_q == 16'd0) begin
          if (job_q.mix_rot == 8'd0) begin
            timer_d = SETTLE_LOAD;
            state_d = ST_ROUTE_OUT;
          end else begin
            rot_d   = job_q.mix_rot;
            state_d = ST_MIX;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_MIX: begin
        if (rotation_tick) begin
          if (rot_q == 8'd1) begin
            timer_d = SETTLE_LOAD;
            state_d = ST_ROUTE_OUT;
          end else begin
            rot_d = rot_q - 8'd1;
          end
        end
      end
      ST_ROUTE_OUT: begin
        if (timer_q == 16'd0) begin
          rot_d   = DRAIN_LOAD;
          state_d = ST_DRAIN;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_DRAIN: begin
        if (rotation_tick && (rot_q == 8'd1)) begin
          state_d = ST_DONE;
        end else if (rotation_tick) begin
          rot_d = rot_q - 8'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // DONE and ABORT are single-cycle exits, so abort only matters while a job runs.
    if (abort && (state_q inside {ST_ROUTE_IN, ST_FILL, ST_SEAL, ST_MIX, ST_ROUTE_OUT, ST_DRAIN})) begin
      state_d = ST_ABORT;
    end

    valve_d = static_valves(state_d, job_d);
  end

  assign pump_enable = is_pumping(state_d);
  assign pump_clear  = pump_enable && (state_d != state_q);

  peristaltic_phase_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_phase_gen (
    .clk           (clk),
    .rst           (rst),
    .enable        (pump_enable),
    .clear         (pump_clear),
    .pattern       (pump_pat),
    .rotation_tick (rotation_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= 16'd0;
      rot_q   <= 8'd0;
      job_q   <= '0;
      valve_q <= VALVES_CLOSED;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rot_q   <= rot_d;
      job_q   <= job_d;
      valve_q <= valve_d;
    end
  end

  always_comb begin
    valve          = valve_q;
    valve[V_CB3_1] = pump_pat[2];
    valve[V_CB3_2] = pump_pat[1];
    valve[V_CB3_3] = pump_pat[0];
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign aborted   = (state_q == ST_ABORT);

endmodule
